// File: rtl/sqsum_inverse_pkg.sv
// Shared types and constants for the square-pyramidal inverse search.
// State encoding, default datapath width and the worst-case n at 32 bits.
package sqsum_pkg;
  localparam int unsigned SQSUM_W         = 32;
  localparam int unsigned SQSUM_MAX_N_W32 = 2343;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sqsum_inverse_if.sv
// Handshake and result bundle between a requester and sqsum_inverse.
interface sqsum_inverse_if #(
  parameter int unsigned W = sqsum_pkg::SQSUM_W
);
  logic         start;
  logic [W-1:0] s_in;
  logic         busy;
  logic         done;
  logic [W-1:0] n_out;
  logic [W-1:0] rem;
  logic         exact;
  logic         err;

  modport master (
    output start, s_in,
    input  busy, done, n_out, rem, exact, err
  );

  modport slave (
    input  start, s_in,
    output busy, done, n_out, rem, exact, err
  );
endinterface

// File: rtl/sqsum_inverse_step.sv
// Incremental running-sum datapath: j, acc = sum of i^2 up to j, sq_nx = (j+1)^2.
import sqsum_pkg::*;

module sqsum_step #(
  parameter int unsigned W = SQSUM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         advance,
  output logic [W-1:0] j,
  output logic [W:0]   acc,
  output logic [W:0]   sq_nx
);
  logic [W-1:0] j_q, j_d;
  logic [W:0]   acc_q, acc_d;
  logic [W:0]   sq_nx_q, sq_nx_d;

  always_comb begin
    j_d     = j_q;
    acc_d   = acc_q;
    sq_nx_d = sq_nx_q;
    if (clear) begin
      j_d     = '0;
      acc_d   = '0;
      sq_nx_d = (W+1)'(1);
    end else if (advance) begin
      // (j+2)^2 = (j+1)^2 + 2j + 3, using the pre-increment j
      j_d     = j_q + W'(1);
      acc_d   = acc_q + sq_nx_q;
      sq_nx_d = sq_nx_q + ((W+1)'(j_q) << 1) + (W+1)'(3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j_q     <= '0;
      acc_q   <= '0;
      sq_nx_q <= '0;
    end else begin
      j_q     <= j_d;
      acc_q   <= acc_d;
      sq_nx_q <= sq_nx_d;
    end
  end

  assign j     = j_q;
  assign acc   = acc_q;
  assign sq_nx = sq_nx_q;
endmodule

// File: rtl/sqsum_inverse.sv
// Finds the largest n with sum_{i=0..n} i^2 <= target, one term per clock.
// Define SQSUM_LIMIT_EN to stop at j == MAX_N and flag err.
import sqsum_pkg::*;

module sqsum_inverse #(
  parameter int unsigned W     = SQSUM_W,
  parameter int unsigned MAX_N = 4095
) (
  input  logic            clk,
  input  logic            rst,
  sqsum_inverse_if.slave  bus
);
`ifdef SQSUM_LIMIT_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  state_t       state_q, state_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W-1:0] n_out_q, n_out_d;
  logic [W-1:0] rem_q, rem_d;
  logic         exact_q, exact_d;
  logic         err_q, err_d;

  logic         clear, advance;
  logic [W-1:0] j;
  logic [W:0]   acc, sq_nx, sum_nx;
  logic         at_cap;

  sqsum_step #(.W(W)) u_step (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (advance),
    .j       (j),
    .acc     (acc),
    .sq_nx   (sq_nx)
  );

  assign sum_nx = acc + sq_nx;
  assign at_cap = CAP_EN && (j == W'(MAX_N));

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    n_out_d = n_out_q;
    rem_d   = rem_q;
    exact_d = exact_q;
    err_d   = err_q;
    clear   = 1'b0;
    advance = 1'b0;
    // busy/done trail the state by one edge so done lands at start + n + 2
    busy_d  = (state_q == RUN);
    done_d  = (state_q == DONE);
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          tgt_d   = bus.s_in;
          clear   = 1'b1;
          done_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (sum_nx > {1'b0, tgt_q}) begin
          state_d = DONE;
          n_out_d = j;
          rem_d   = tgt_q - acc[W-1:0];
          exact_d = ({1'b0, tgt_q} == acc);
          err_d   = 1'b0;
        end else if (at_cap) begin
          state_d = DONE;
          n_out_d = j;
          rem_d   = tgt_q - acc[W-1:0];
          exact_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      n_out_q <= '0;
      rem_q   <= '0;
      exact_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      n_out_q <= n_out_d;
      rem_q   <= rem_d;
      exact_q <= exact_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.n_out = n_out_q;
  assign bus.rem   = rem_q;
  assign bus.exact = exact_q;
  assign bus.err   = err_q;
endmodule
